memory_stage: RTL and testbench

Pipeline MEM stage: captures the Execute-stage outputs into the E/M register, resolves branch/jump redirect, runs a valid/ready data-memory access for loads and stores, and drives the M/W register feeding writeback. While a memory access is outstanding it asserts `stall_m`; the hazard unit uses this to freeze F/D/E.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/dmem_access_fsm.sv | 52 +++++
 rtl/memory_stage.sv | 107 ++++++++++
 tb/tb_memory_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the MEM stage: word/register-index types,
// data-memory FSM states and the bundled E/M register contents.
package pipeline_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_e;

    typedef struct packed {
        word_t    alu_out;
        word_t    write_data;
        word_t    pc_branch;
        word_t    jump_addr;
        reg_idx_t write_reg;
        logic     reg_write;
        logic     mem_to_reg;
        logic     mem_write;
        logic     branch;
        logic     zero;
        logic     j_inst;
    } em_reg_t;

    // Data memory is word-addressed; byte offset bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer for the MEM stage: valid/ready request,
// load-response wait, stall generation and read-data capture.
module dmem_access_fsm
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_write_m,
    input  logic            next_mem_op,
    input  logic            dmem_req_ready,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic            dmem_req_valid,
    output logic            stall_m,
    output logic [XLEN-1:0] read_data_w
);

    mem_state_e state;

    always_comb begin
        stall_m = 1'b0;
        case (state)
            REQ:     stall_m = ~mem_write_m | ~dmem_req_ready;
            WAIT:    stall_m = ~dmem_resp_valid;
            default: stall_m = 1'b0;
        endcase
    end

    // On an advancing edge the next state is decided by the instruction
    // entering MEM, not by the one leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dmem_req_valid <= 1'b0;
            read_data_w    <= '0;
        end else begin
            if (state == WAIT && dmem_resp_valid) begin
                read_data_w <= dmem_resp_rdata;
            end
            if (!stall_m) begin
                state          <= next_mem_op ? REQ : IDLE;
                dmem_req_valid <= next_mem_op;
            end else if (state == REQ && dmem_req_ready) begin
                state          <= WAIT;
                dmem_req_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: E/M register, branch/jump redirect, data-memory
// access via dmem_access_fsm, and the M/W register feeding writeback.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_out_e,
    input  logic [XLEN-1:0] write_data_e,
    input  logic [XLEN-1:0] pc_branch_e,
    input  logic [XLEN-1:0] jump_addr_e,
    input  logic [RA_W-1:0] write_reg_e,
    input  logic            reg_write_e,
    input  logic            mem_to_reg_e,
    input  logic            mem_write_e,
    input  logic            branch_e,
    input  logic            zero_e,
    input  logic            j_inst_e,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic            stall_m,
    output logic            pc_src_m,
    output logic [XLEN-1:0] pc_target_m,
    output logic [XLEN-1:0] alu_out_m,
    output logic [RA_W-1:0] write_reg_m,
    output logic            reg_write_m,
    output logic [XLEN-1:0] result_w,
    output logic [RA_W-1:0] write_reg_w,
    output logic            reg_write_w
);

    em_reg_t         em;
    logic [XLEN-1:0] alu_out_w;
    logic [XLEN-1:0] read_data_w;
    logic            mem_to_reg_w;
    logic            next_mem_op;

    assign next_mem_op = mem_to_reg_e | mem_write_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            em <= '0;
        end else if (!stall_m) begin
            em.alu_out    <= alu_out_e;
            em.write_data <= write_data_e;
            em.pc_branch  <= pc_branch_e;
            em.jump_addr  <= jump_addr_e;
            em.write_reg  <= write_reg_e;
            em.reg_write  <= reg_write_e;
            em.mem_to_reg <= mem_to_reg_e;
            em.mem_write  <= mem_write_e;
            em.branch     <= branch_e;
            em.zero       <= zero_e;
            em.j_inst     <= j_inst_e;
        end
    end

    dmem_access_fsm #(.XLEN(XLEN)) u_fsm (
        .clk             (clk),
        .rst             (rst),
        .mem_write_m     (em.mem_write),
        .next_mem_op     (next_mem_op),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .dmem_req_valid  (dmem_req_valid),
        .stall_m         (stall_m),
        .read_data_w     (read_data_w)
    );

    assign dmem_req_we    = em.mem_write;
    assign dmem_req_addr  = word_align(em.alu_out);
    assign dmem_req_wdata = em.write_data;

    assign pc_src_m    = ((em.branch & em.zero) | em.j_inst) & ~stall_m;
    assign pc_target_m = em.j_inst ? em.jump_addr : em.pc_branch;

    assign alu_out_m   = em.alu_out;
    assign write_reg_m = em.write_reg;
    assign reg_write_m = em.reg_write;

    // A stalled edge pushes a fully zeroed bubble into W.
    always_ff @(posedge clk) begin
        if (rst || stall_m) begin
            alu_out_w    <= '0;
            write_reg_w  <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            alu_out_w    <= em.alu_out;
            write_reg_w  <= em.write_reg;
            reg_write_w  <= em.reg_write;
            mem_to_reg_w <= em.mem_to_reg;
        end
    end

    assign result_w = mem_to_reg_w ? read_data_w : alu_out_w;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_memory_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
    logic [4:0]  write_reg_e;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, zero_e, j_inst_e;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall_m, pc_src_m;
    logic [31:0] pc_target_m, alu_out_m, result_w;
    logic [4:0]  write_reg_m, write_reg_w;
    logic        reg_write_m, reg_write_w;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt;

    // Reference model: instruction held in MEM, whether its load request
    // was already accepted, and the writeback-visible values.
    em_reg_t     mi;
    logic        m_acc;
    logic        w_rw, w_m2r;
    logic [31:0] w_alu, w_rd;
    logic [4:0]  w_wr;

    memory_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_out_e(alu_out_e), .write_data_e(write_data_e),
        .pc_branch_e(pc_branch_e), .jump_addr_e(jump_addr_e),
        .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
        .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .zero_e(zero_e), .j_inst_e(j_inst_e),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .stall_m(stall_m), .pc_src_m(pc_src_m), .pc_target_m(pc_target_m),
        .alu_out_m(alu_out_m), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
        .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_nop();
        alu_out_e = '0; write_data_e = '0; pc_branch_e = '0; jump_addr_e = '0;
        write_reg_e = '0; reg_write_e = 0; mem_to_reg_e = 0; mem_write_e = 0;
        branch_e = 0; zero_e = 0; j_inst_e = 0;
    endtask

    task automatic model_reset();
        mi = '0; m_acc = 0;
        w_rw = 0; w_m2r = 0; w_alu = '0; w_rd = '0; w_wr = '0;
    endtask

    // One clock: compare at negedge, then advance the model on the posedge.
    task automatic cycle();
        logic is_mem, req, retire;
        @(negedge clk);
        is_mem = mi.mem_to_reg | mi.mem_write;
        req    = is_mem & ~m_acc;
        retire = ~is_mem | (req & mi.mem_write & dmem_req_ready) | (m_acc & dmem_resp_valid);
        chk("stall_m", {31'b0, stall_m}, {31'b0, ~retire});
        chk("req_valid", {31'b0, dmem_req_valid}, {31'b0, req});
        if (req) begin
            chk("req_we", {31'b0, dmem_req_we}, {31'b0, mi.mem_write});
            chk("req_addr", dmem_req_addr, {mi.alu_out[31:2], 2'b00});
            chk("req_wdata", dmem_req_wdata, mi.write_data);
        end
        chk("pc_src_m", {31'b0, pc_src_m}, {31'b0, ((mi.branch & mi.zero) | mi.j_inst) & retire});
        chk("pc_target_m", pc_target_m, mi.j_inst ? mi.jump_addr : mi.pc_branch);
        chk("alu_out_m", alu_out_m, mi.alu_out);
        chk("write_reg_m", {27'b0, write_reg_m}, {27'b0, mi.write_reg});
        chk("reg_write_m", {31'b0, reg_write_m}, {31'b0, mi.reg_write});
        chk("reg_write_w", {31'b0, reg_write_w}, {31'b0, w_rw});
        chk("write_reg_w", {27'b0, write_reg_w}, {27'b0, w_wr});
        chk("result_w", result_w, w_m2r ? w_rd : w_alu);
        if (stall_m) stall_cnt++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (retire) begin
            w_rw = mi.reg_write; w_m2r = mi.mem_to_reg; w_alu = mi.alu_out; w_wr = mi.write_reg;
            if (m_acc && dmem_resp_valid) w_rd = dmem_resp_rdata;
            mi = '{alu_out: alu_out_e, write_data: write_data_e, pc_branch: pc_branch_e,
                   jump_addr: jump_addr_e, write_reg: write_reg_e, reg_write: reg_write_e,
                   mem_to_reg: mem_to_reg_e, mem_write: mem_write_e, branch: branch_e,
                   zero: zero_e, j_inst: j_inst_e};
            m_acc = 0;
        end else begin
            w_rw = 0; w_m2r = 0; w_alu = '0; w_wr = '0;
            if (req && dmem_req_ready && !mi.mem_write) m_acc = 1;
        end
        #1;
    endtask

    task automatic rand_inputs();
        set_nop();
        alu_out_e    = $urandom;
        write_data_e = $urandom;
        pc_branch_e  = $urandom;
        jump_addr_e  = $urandom;
        write_reg_e  = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: reg_write_e = 1;
            1: begin mem_to_reg_e = 1; reg_write_e = 1; end
            2: mem_write_e = 1;
            default: begin
                branch_e = 1'($urandom_range(0, 1));
                zero_e   = 1'($urandom_range(0, 1));
                j_inst_e = 1'($urandom_range(0, 1));
            end
        endcase
        dmem_req_ready  = ($urandom_range(0, 9) < 7);
        dmem_resp_valid = 1'($urandom_range(0, 1));
        dmem_resp_rdata = $urandom;
        rst             = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        model_reset();
        set_nop();
        dmem_resp_valid = 0; dmem_resp_rdata = '0;

        // Reset with a load pending on the inputs and ready high.
        rst = 1; dmem_req_ready = 1;
        alu_out_e = 32'h0000_0203; mem_to_reg_e = 1; reg_write_e = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
            cycle();
        end
        rst = 0; set_nop();
        cycle();

        // ALU op.
        alu_out_e = 32'h1234; write_reg_e = 5'd7; reg_write_e = 1;
        stall_cnt = 0;
        cycle();
        set_nop();
        chk("alu_m", alu_out_m, 32'h1234);
        cycle();
        chk("alu_result_w", result_w, 32'h1234);
        chk("alu_write_reg_w", {27'b0, write_reg_w}, 32'd7);
        chk("alu_no_stall", stall_cnt, 0);

        // Store with two cycles of backpressure.
        mem_write_e = 1; alu_out_e = 32'h100; write_data_e = 32'hDEAD_BEEF;
        dmem_req_ready = 0;
        cycle();
        set_nop();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dmem_req_ready = 1;
            chk("st_valid", {31'b0, dmem_req_valid}, 32'd1);
            chk("st_addr", dmem_req_addr, 32'h100);
            chk("st_wdata", dmem_req_wdata, 32'hDEAD_BEEF);
            cycle();
        end
        chk("st_stalls", stall_cnt, 2);
        chk("st_bubble", {31'b0, reg_write_w}, 32'd0);

        // Load: accepted immediately, response in the third WAIT cycle.
        alu_out_e = 32'h203; mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5'd3;
        cycle();
        set_nop();
        chk("ld_addr", dmem_req_addr, 32'h200);
        stall_cnt = 0;
        cycle();
        cycle();
        cycle();
        dmem_resp_valid = 1; dmem_resp_rdata = 32'hCAFE_F00D;
        cycle();
        dmem_resp_valid = 0;
        chk("ld_stalls", stall_cnt, 3);
        chk("ld_result", result_w, 32'hCAFE_F00D);
        chk("ld_reg_write_w", {31'b0, reg_write_w}, 32'd1);
        cycle();
        chk("ld_once", {31'b0, reg_write_w}, 32'd0);

        // Branch taken, branch not taken, jump.
        branch_e = 1; zero_e = 1; pc_branch_e = 32'h40;
        cycle();
        set_nop();
        chk("br_src", {31'b0, pc_src_m}, 32'd1);
        chk("br_target", pc_target_m, 32'h40);
        branch_e = 1; zero_e = 0; pc_branch_e = 32'h40;
        cycle();
        set_nop();
        chk("br_nt_src", {31'b0, pc_src_m}, 32'd0);
        j_inst_e = 1; jump_addr_e = 32'h80; pc_branch_e = 32'h44;
        cycle();
        set_nop();
        chk("j_src", {31'b0, pc_src_m}, 32'd1);
        chk("j_target", pc_target_m, 32'h80);
        cycle();

        // Reset while a load sits in WAIT, then a late response.
        alu_out_e = 32'h300; mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5'd9;
        cycle();
        set_nop();
        cycle();
        rst = 1;
        cycle();
        rst = 0; dmem_resp_valid = 1; dmem_resp_rdata = 32'h5555_AAAA;
        chk("rw_stall", {31'b0, stall_m}, 32'd0);
        chk("rw_valid", {31'b0, dmem_req_valid}, 32'd0);
        cycle();
        dmem_resp_valid = 0;
        chk("rw_no_write", {31'b0, reg_write_w}, 32'd0);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
